instr_decode_pipe: RTL
======================

# instr_decode_pipe

Parametrised, handshaked instruction decoder for the JSilicon core. It sits between the program counter/fetch stage and the ALU/register file and replaces the single-word, always-advancing decoder. It accepts instruction words over a valid/ready interface and decodes them into registered ALU control fields. An optional two-word extended form carries a full-width immediate. The output is a one-entry register stage with back-pressure, so a stalled ALU never loses an instruction.

## Interface
- INSTR_W, default 8: instruction word width; also the width of `operand`.
- OPC_W, default 3: opcode field width, taken from `instr_in[INSTR_W-1 -: OPC_W]`.
- Derived field widths:
  - Field width FLD_W = INSTR_W-OPC_W-1; requires FLD_W >= OPC_W.
  - The select bit is `instr_in[FLD_W]`; the short operand is `instr_in[FLD_W-1:0]`.
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- ena  in  1  advance enable; when low, all state holds.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  decoder accepts a word this cycle.
- instr_in  in  INSTR_W  instruction word.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  consumer takes the decoded fields.
- alu_opcode  out  OPC_W  ALU opcode.
- reg_sel  out  1  destination register select.
- operand  out  INSTR_W  immediate: zero-extended short operand, or the full extended immediate.
- alu_enable  out  1  ALU must execute.
- write_enable  out  1  register write permitted.
- ext  out  1  instruction was the two-word extended form.
- illegal  out  1  undefined opcode decoded.

## Operation
- Handshake rules:
  - in_ready = ena & ~flush & (~out_valid | out_ready).
  - A word is accepted when in_valid & in_ready.
  - Output fields change only when a new decode is loaded.
- Opcode map for OPC_W=3; generalised by value:
  - 0–4 (ADD, SUB, MUL, DIV, MOD): alu_enable=1, write_enable=1.
  - 5 (CMP): alu_enable=1, write_enable=0.
  - 6 (NOP): both enables 0, illegal=0.
  - All-ones (7): extended prefix; see Configuration.
  - Any other value, for OPC_W>3: both enables 0, illegal=1.
- FSM states:
  - S_OP: waiting for the first word.
    - Non-prefix word accepted: load the output register with out_valid=1, ext=0, operand={zeros, short operand}; stay in S_OP.
    - Prefix word accepted: latch real opcode = `instr_in[OPC_W-1:0]` and sel bit into a pending register; out_valid is unchanged apart from normal consumption; go to S_IMM.
  - S_IMM: waiting for the immediate word.
    - Next accepted word is the immediate.
    - Load alu_opcode = pending opcode, reg_sel = pending sel, operand = instr_in, ext=1; set enables from the pending opcode; go to S_OP.
    - If the pending opcode is 6 or all-ones: enables 0, illegal=1 (both words still consumed).
- Output consumption:
  - out_valid & out_ready with no new load in the same cycle clears out_valid.
  - A simultaneous load keeps out_valid=1 with the new fields.
- flush, when ena=1:
  - Clears out_valid; returns the FSM to S_OP; discards any pending prefix.
  - No word is accepted that cycle; fields are not cleared.
- ena=0: FSM, out_valid and fields hold; in_ready=0; flush is ignored.
- Reset:
  - out_valid=0, all fields 0 (alu_opcode, reg_sel, operand, alu_enable, write_enable, ext, illegal).
  - FSM=S_OP, pending registers 0.
  - in_ready=0 while reset is high.

## Timing
- Latency: fields and out_valid appear on the clock edge that accepts the final word of an instruction, i.e. visible in the following cycle.
- Throughput: one short instruction per cycle; one extended instruction per two cycles when out_ready is held high.
- A back-pressure stall holds the fields stable for any number of cycles.
- Reset mid-extended instruction abandons the prefix; the next word is decoded in S_OP.

## Configuration
- DECODER_EXT_EN defined:
  - The all-ones opcode is the extended prefix.
  - The S_IMM state and pending registers exist.
  - ext can assert.
- DECODER_EXT_EN undefined:
  - The all-ones opcode is a single-word undefined instruction: both enables 0, illegal=1, ext held 0.
  - The FSM is permanently S_OP; no pending registers.

## Test plan
- Reset, then instr 0x23 with out_ready=1 → next cycle out_valid=1, alu_opcode=1, reg_sel=0, operand=0x03, alu_enable=1, write_enable=1, illegal=0.
- 0xB5 → alu_opcode=5, reg_sel=1, operand=0x05, alu_enable=1, write_enable=0.
- Extended, DECODER_EXT_EN on:
  - 0xF2 then 0x7F → only after the second word: alu_opcode=2, reg_sel=1, operand=0x7F, ext=1, enables 1.
  - 0xF6 then 0x00 → illegal=1, enables 0.
- Back-pressure: 0x01 then 0x42 with out_ready=0 → first decode held, in_ready=0; out_ready=1 → 0x42 loaded the next cycle with no loss or duplication.
- flush: assert flush after prefix 0xF1 → out_valid=0; next 0x23 decodes as a short ADD-class instruction (alu_opcode=1), not as an immediate.
- DECODER_EXT_EN off: 0xF2 → single-cycle decode with illegal=1, ext=0, enables 0; next word decoded normally.

Source files
------------

// File: rtl/instr_decode_pipe.sv
// Handshaked JSilicon instruction decoder with a one-entry registered output stage.
// Define DECODER_EXT_EN to enable the two-word extended form (all-ones opcode prefix + full-width immediate).
module instr_decode_pipe #(
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ena,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   alu_opcode,
  output logic               reg_sel,
  output logic [INSTR_W-1:0] operand,
  output logic               alu_enable,
  output logic               write_enable,
  output logic               ext,
  output logic               illegal
);

  localparam int FLD_W = INSTR_W - OPC_W - 1;
  localparam logic [OPC_W-1:0] OPC_LAST_ALU = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_CMP      = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_NOP      = OPC_W'(6);

  // Returns {alu_enable, write_enable, illegal} for a decoded opcode value.
  function automatic logic [2:0] opcode_ctl(input logic [OPC_W-1:0] opc);
    if (opc <= OPC_LAST_ALU)  return 3'b110;
    else if (opc == OPC_CMP)  return 3'b100;
    else if (opc == OPC_NOP)  return 3'b000;
    else                      return 3'b001;
  endfunction

  // Handshake: a word moves when in_valid & in_ready; in_ready needs ena, no flush,
  // and an empty output stage or one being drained this cycle. Output moves on out_valid & out_ready.
  logic [OPC_W-1:0]   word_opc;
  logic               accept;
  logic               load;
  logic [OPC_W-1:0]   ld_opc;
  logic               ld_sel;
  logic [INSTR_W-1:0] ld_operand;
  logic               ld_ext;
  logic [2:0]         ld_ctl;

  assign word_opc = instr_in[INSTR_W-1 -: OPC_W];
  assign in_ready = ~reset & ena & ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

`ifdef DECODER_EXT_EN
  typedef enum logic {S_OP, S_IMM} state_t;
  localparam logic [OPC_W-1:0] OPC_PREFIX = '1;

  state_t           state;
  logic [OPC_W-1:0] pend_opc;
  logic             pend_sel;
  logic             take_prefix;

  assign take_prefix = (state == S_OP) && (word_opc == OPC_PREFIX);
  assign load        = accept & ~take_prefix;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_OP;
      pend_opc <= '0;
      pend_sel <= 1'b0;
    end else if (ena) begin
      if (flush) begin
        state    <= S_OP;
        pend_opc <= '0;
        pend_sel <= 1'b0;
      end else if (accept) begin
        if (take_prefix) begin
          state    <= S_IMM;
          pend_opc <= instr_in[OPC_W-1:0];
          pend_sel <= instr_in[FLD_W];
        end else begin
          state <= S_OP;
        end
      end
    end
  end
`else
  assign load = accept;
`endif

  always_comb begin
    ld_opc     = word_opc;
    ld_sel     = instr_in[FLD_W];
    ld_operand = {{(INSTR_W-FLD_W){1'b0}}, instr_in[FLD_W-1:0]};
    ld_ext     = 1'b0;
    ld_ctl     = opcode_ctl(word_opc);
`ifdef DECODER_EXT_EN
    if (state == S_IMM) begin
      ld_opc     = pend_opc;
      ld_sel     = pend_sel;
      ld_operand = instr_in;
      ld_ext     = 1'b1;
      // NOP and a nested prefix have no meaning behind a prefix.
      ld_ctl     = ((pend_opc == OPC_NOP) || (pend_opc == OPC_PREFIX)) ? 3'b001
                                                                      : opcode_ctl(pend_opc);
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      alu_opcode   <= '0;
      reg_sel      <= 1'b0;
      operand      <= '0;
      alu_enable   <= 1'b0;
      write_enable <= 1'b0;
      ext          <= 1'b0;
      illegal      <= 1'b0;
    end else if (ena) begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid    <= 1'b1;
        alu_opcode   <= ld_opc;
        reg_sel      <= ld_sel;
        operand      <= ld_operand;
        alu_enable   <= ld_ctl[2];
        write_enable <= ld_ctl[1];
        ext          <= ld_ext;
        illegal      <= ld_ctl[0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
